serial_adder_seq: RTL
=====================

// Module: serial_adder_seq
// PURPOSE
//  Bit-serial adder. Loads two WIDTH-bit operands on a start pulse, then adds them
//  LSB-first at one bit per clock through a single full-adder cell and a carry flop.
//  The full-adder cell is two half adders plus an OR gate.
//  Registered sum/carry are presented with a one-cycle done pulse.
//  It is the sequential, additive counterpart of the combinational half-subtractor
//  cells in the adders/subtractors library. It sits between operand registers and a
//  result consumer.
// PARAMETERS
//  WIDTH  4  operand/sum width in bits; legal range 2..32
// PORTS
//  clk    in   1      rising-edge clock, single clock domain
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only when ready (state IDLE or DONE)
//  a      in   WIDTH  operand A; captured on the accepting edge
//  b      in   WIDTH  operand B; captured on the accepting edge
//  sub    in   1      mode select; present only with SERIAL_SUB_EN; captured with a/b
//  sum    out  WIDTH  result; registered; held until the next accepted start
//  cout   out  1      carry out (borrow out in subtract mode); registered
//  busy   out  1      high while bits are being processed
//  done   out  1      one-cycle pulse when sum/cout become valid
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - state=IDLE; sum=0, cout=0, busy=0, done=0.
//    - Shift registers, carry flop and bit counter are cleared.
//  - FSM:
//    - IDLE --start--> RUN.
//    - RUN --(bit count == WIDTH-1 processed)--> DONE.
//    - DONE --start--> RUN; DONE --!start--> IDLE.
//  - Accept edge k (start=1 in IDLE/DONE):
//    - Capture a, b into shift regs; carry=0; cnt=0.
//    - Assert busy=1; clear done=0.
//    - Clear sum and cout to 0.
//  - Processing edges k+1..k+WIDTH: edge k+1+i handles bit i.
//    - s_i = a_i ^ b_i ^ c.
//    - c' = a_i&b_i | c&(a_i^b_i).
//    - s_i is shifted into sum from the MSB side, so bit i lands at sum[i] after the last shift.
//  - Edge k+WIDTH: state=DONE, busy=0, done=1, cout=final carry.
//    - sum holds the full WIDTH-bit result.
//  - Latency: accept edge to done high = WIDTH edges. Throughput: one op per WIDTH+1 cycles.
//  - done is high exactly one cycle. sum/cout hold until the next accepted start clears them.
//  - start while busy: ignored; operands are not resampled; the operation is unaffected.
//  - start in DONE: accepted (back-to-back). done drops the same edge busy rises.
//  - Arithmetic: sum = (a+b) mod 2^WIDTH; cout = bit WIDTH of a+b.
//    - No overflow flag; signedness is the consumer's concern.
//  - Reset asserted mid-RUN: operation aborts immediately; all outputs return to reset values.
//    - No done is issued for the aborted op.
//  - a/b changes after the accept edge have no effect.
// CONFIGURATION
//  SERIAL_SUB_EN defined:
//    - Port sub exists.
//    - sub=1 at accept: cell acts as a full subtractor.
//      - d_i = a_i ^ b_i ^ w.
//      - w' = ~a_i&b_i | w&~(a_i^b_i).
//      - w starts at 0.
//      - sum = (a-b) mod 2^WIDTH; cout = borrow out (1 when a<b).
//    - sub=0: addition exactly as above.
//  SERIAL_SUB_EN undefined: no sub port; adder only. Logic and timing are otherwise identical.
// TESTING (WIDTH=4)
//  1 rst=1 then release -> sum=0, cout=0, busy=0, done=0. start=1 a=3 b=5 ->
//    busy for 4 cycles; done pulse 4 edges after accept; sum=8, cout=0.
//  2 a=15 b=1 -> sum=0, cout=1. Then a=0 b=0 -> sum=0, cout=0.
//    Check sum/cout hold after done falls.
//  3 start with a=2 b=2; pulse start again mid-RUN with a=7 b=7 ->
//    result sum=4, cout=0; the second start is ignored; only one done.
//  4 start held high continuously with a=9 b=9 -> ops repeat every 5 cycles;
//    each op gives sum=2, cout=1.
//  5 start a=6 b=7; assert rst on the 2nd RUN cycle -> all outputs 0 at once; no done.
//    After release, a=1 b=1 -> sum=2.
//  6 (SERIAL_SUB_EN) sub=1 a=3 b=5 -> sum=14, cout=1.
//    sub=1 a=9 b=4 -> sum=5, cout=0.

Source files
------------

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// Optional macro SERIAL_SUB_EN adds a sub port that turns the cell into a full subtractor.
module serial_adder_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             cell_s;
  logic             cell_c;
  logic             accept;

  // Returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic [1:0] h1;
    logic [1:0] h2;
    h1 = half_add(x, y);
    h2 = half_add(h1[0], ci);
    return {h1[1] | h2[1], h2[0]};
  endfunction

`ifdef SERIAL_SUB_EN
  logic sub_q;

  // Returns {borrow, difference}.
  function automatic logic [1:0] half_sub(input logic x, input logic y);
    return {~x & y, x ^ y};
  endfunction

  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic wi);
    logic [1:0] h1;
    logic [1:0] h2;
    h1 = half_sub(x, y);
    h2 = half_sub(h1[0], wi);
    return {h1[1] | h2[1], h2[0]};
  endfunction
`endif

  always_comb begin
    cell_s = 1'b0;
    cell_c = 1'b0;
`ifdef SERIAL_SUB_EN
    if (sub_q) {cell_c, cell_s} = full_sub(sa[0], sb[0], carry);
    else       {cell_c, cell_s} = full_add(sa[0], sb[0], carry);
`else
    {cell_c, cell_s} = full_add(sa[0], sb[0], carry);
`endif
  end

  assign accept = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SERIAL_SUB_EN
      sub_q <= 1'b0;
`endif
    end else if (accept) begin
      state <= RUN;
      sa    <= a;
      sb    <= b;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b1;
      done  <= 1'b0;
`ifdef SERIAL_SUB_EN
      sub_q <= sub;
`endif
    end else begin
      case (state)
        RUN: begin
          // Each result bit enters at the MSB so bit i settles at sum[i] after WIDTH shifts.
          sum   <= {cell_s, sum[WIDTH-1:1]};
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= cell_c;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= cell_c;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
